// File: rtl/mem_responder_if.sv
// CPU-side memory bus: request strobes, address/data and completion handshake.
// The CPU datapath drives through master, the responder attaches through slave.
interface mem_responder_if;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        MEM_RD;
    logic        MEM_WR;
    logic [15:0] SW;
    logic        MEM_READY;
    logic        MEM_BUSY;
    logic [15:0] Data_to_CPU;
    logic [15:0] HEX_Data;

    modport master (
        output MAR, MDR, MEM_RD, MEM_WR, SW,
        input  MEM_READY, MEM_BUSY, Data_to_CPU, HEX_Data
    );

    modport slave (
        input  MAR, MDR, MEM_RD, MEM_WR, SW,
        output MEM_READY, MEM_BUSY, Data_to_CPU, HEX_Data
    );
endinterface

// File: rtl/mem_responder.sv
// Wait-stated memory responder: RAM plus one I/O word at 0xFFFF (HEX on write, switches on read).
// Completion is a one-cycle MEM_READY pulse WAIT_CYCLES+1 cycles after acceptance; new requests only in IDLE.
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [15:0] IO_ADDR  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q, busy_q;
    logic [15:0] rdata_q, hex_q;
    logic [15:0] sw_meta_q, sw_sync_q;

    logic [15:0] ram_q [2**DEPTH_LOG2];

    logic                  commit;
    logic                  is_io;
    logic [DEPTH_LOG2-1:0] ram_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.MEM_WR || bus.MEM_RD) begin
                    // a write wins when both strobes are high
                    wr_d    = bus.MEM_WR;
                    addr_d  = bus.MAR;
                    wdata_d = bus.MDR;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // _d views cover the zero-wait case where acceptance and commit share an edge
    assign commit  = (state_d == RESP) && (state_q != RESP);
    assign is_io   = (addr_d == IO_ADDR);
    assign ram_idx = addr_d[DEPTH_LOG2-1:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= 16'h0000;
            hex_q     <= 16'h0000;
            sw_meta_q <= 16'h0000;
            sw_sync_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= (state_d == RESP);
            busy_q    <= (state_d != IDLE);
            sw_meta_q <= bus.SW;
            sw_sync_q <= sw_meta_q;
            if (commit) begin
                if (wr_d) begin
                    if (is_io) begin
                        hex_q <= wdata_d;
                    end
                end else begin
                    rdata_q <= is_io ? sw_sync_q : ram_q[ram_idx];
                end
            end
        end
    end

    // RAM has no reset; Reset gating keeps an aborted access from committing
    always_ff @(posedge Clk) begin
        if (commit && wr_d && !is_io && !Reset) begin
            ram_q[ram_idx] <= wdata_d;
        end
    end

    assign bus.MEM_READY   = ready_q;
    assign bus.MEM_BUSY    = busy_q;
    assign bus.Data_to_CPU = rdata_q;
    assign bus.HEX_Data    = hex_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: a 2-wait-state instance under directed and random traffic,
// plus a zero-wait instance for back-to-back acceptance.
module tb_mem_responder;
    localparam int WAIT = 2;

    logic        Clk;
    logic        Reset;
    logic [15:0] sw_v;
    int          cyc;
    int          n_checks;
    int          n_fail;

    mem_responder_if ifc0 ();
    mem_responder_if ifc1 ();

    assign ifc0.SW = sw_v;
    assign ifc1.SW = sw_v;

    mem_responder #(.WAIT_CYCLES(WAIT), .DEPTH_LOG2(8)) dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc0.slave)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc1.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] hex;
        int          cyc;
    } exp_t;

    exp_t        sb_q [$];
    logic [15:0] mem_m [256];
    logic [15:0] rd_m;
    logic [15:0] hex_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every completion pulse is matched against the oldest outstanding expectation
    always @(negedge Clk) begin
        if (Reset === 1'b0 && ifc0.MEM_READY === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected no response", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("data_to_cpu", 32'(ifc0.Data_to_CPU), 32'(e.rd));
                chk("hex_data", 32'(ifc0.HEX_Data), 32'(e.hex));
                chk("latency", 32'(cyc), 32'(e.cyc + WAIT + 1));
            end
        end
    end

    // behavioural model: what the CPU should observe once this access completes
    task automatic model_push(input bit wr, input bit rd, input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        if (wr) begin
            if (addr == 16'hFFFF) hex_m = data;
            else                  mem_m[addr[7:0]] = data;
        end else if (rd) begin
            rd_m = (addr == 16'hFFFF) ? sw_v : mem_m[addr[7:0]];
        end
        e.rd  = rd_m;
        e.hex = hex_m;
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic do_access(input bit wr, input bit rd, input logic [15:0] addr, input logic [15:0] data,
                             input bit change_sw, input logic [15:0] new_sw);
        int k;
        @(negedge Clk);
        ifc0.MEM_WR = wr;
        ifc0.MEM_RD = rd;
        ifc0.MAR    = addr;
        ifc0.MDR    = data;
        model_push(wr, rd, addr, data);
        @(negedge Clk);
        // garbage on the bus while in flight must not matter
        ifc0.MEM_WR = 1'b0;
        ifc0.MEM_RD = 1'b0;
        ifc0.MAR    = 16'($urandom);
        ifc0.MDR    = 16'($urandom);
        if (change_sw) sw_v = new_sw;
        chk("busy_in_flight", 32'(ifc0.MEM_BUSY), 32'd1);
        k = 0;
        while (ifc0.MEM_READY !== 1'b1 && k < 30) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 30) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready in 30 cycles expected ready");
            sb_q.delete();
        end
        @(negedge Clk);
        chk("busy_idle", 32'(ifc0.MEM_BUSY), 32'd0);
        chk("ready_single", 32'(ifc0.MEM_READY), 32'd0);
    endtask

    task automatic set_sw(input logic [15:0] v);
        @(negedge Clk);
        sw_v = v;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int ready_seen;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        sw_v     = 16'h0000;
        rd_m     = 16'h0000;
        hex_m    = 16'h0000;
        Reset    = 1'b1;
        ifc0.MAR = 16'h0; ifc0.MDR = 16'h0; ifc0.MEM_RD = 1'b0; ifc0.MEM_WR = 1'b0;
        ifc1.MAR = 16'h0; ifc1.MDR = 16'h0; ifc1.MEM_RD = 1'b0; ifc1.MEM_WR = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_ready", 32'(ifc0.MEM_READY), 32'd0);
        chk("rst_busy", 32'(ifc0.MEM_BUSY), 32'd0);
        chk("rst_data", 32'(ifc0.Data_to_CPU), 32'd0);
        chk("rst_hex", 32'(ifc0.HEX_Data), 32'd0);
        Reset = 1'b0;

        // give every RAM word a known value
        for (int i = 0; i < 256; i++) do_access(1'b1, 1'b0, 16'(i), 16'($urandom), 1'b0, 16'h0);

        do_access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
        do_access(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0);

        do_access(1'b1, 1'b0, 16'h0105, 16'h1234, 1'b0, 16'h0);
        do_access(1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 16'h0);
        do_access(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 1'b0, 16'h0);
        do_access(1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b0, 16'h0);

        // switch change one cycle into BUSY is too late to reach the read
        set_sw(16'h5A5A);
        do_access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h1111);
        repeat (3) @(negedge Clk);
        do_access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0);

        do_access(1'b1, 1'b1, 16'h0020, 16'h7777, 1'b0, 16'h0);
        do_access(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h0);

        // reset during BUSY aborts the write
        @(negedge Clk);
        ifc0.MEM_WR = 1'b1;
        ifc0.MAR    = 16'h0030;
        ifc0.MDR    = 16'hCAFE;
        @(negedge Clk);
        ifc0.MEM_WR = 1'b0;
        #1 Reset = 1'b1;
        #2 Reset = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (ifc0.MEM_READY === 1'b1) ready_seen++;
        end
        chk("abort_no_ready", 32'(ready_seen), 32'd0);
        chk("abort_data", 32'(ifc0.Data_to_CPU), 32'd0);
        chk("abort_hex", 32'(ifc0.HEX_Data), 32'd0);
        rd_m  = 16'h0000;
        hex_m = 16'h0000;
        do_access(1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 16'h0);

        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            int op;
            if ($urandom_range(5) == 0) set_sw(16'($urandom));
            a  = ($urandom_range(4) == 0) ? 16'hFFFF : 16'($urandom);
            op = $urandom_range(2);
            do_access(op != 1, op != 0, a, 16'($urandom), 1'b0, 16'h0);
        end

        // zero-wait instance: a held read strobe completes every other cycle
        set_sw(16'h3C3C);
        @(negedge Clk);
        ifc1.MAR    = 16'hFFFF;
        ifc1.MEM_RD = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge Clk);
            chk("b2b_ready", 32'(ifc1.MEM_READY), 32'(i % 2));
            chk("b2b_busy", 32'(ifc1.MEM_BUSY), 32'(i % 2));
        end
        ifc1.MEM_RD = 1'b0;
        chk("b2b_data", 32'(ifc1.Data_to_CPU), 32'h3C3C);

        repeat (4) @(negedge Clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of BUSY wait-state cycles per access (0..15).
REQ-002 Parameter DEPTH_LOG2, default 8: internal RAM holds 2^DEPTH_LOG2 16-bit words.
REQ-003 Clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-high; forces every register listed under Reset immediately.
REQ-005 MAR  in  16  request address from the CPU datapath.
REQ-006 MDR  in  16  write data from the CPU datapath.
REQ-007 MEM_RD  in  1  read request strobe.
REQ-008 MEM_WR  in  1  write request strobe.
REQ-009 SW  in  16  asynchronous switch inputs.
REQ-010 MEM_READY  out  1  one-cycle completion pulse.
REQ-011 MEM_BUSY  out  1  high while an access is in flight.
REQ-012 Data_to_CPU  out  16  read data returned to the CPU (MDR_In side).
REQ-013 HEX_Data  out  16  memory-mapped display register.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-015 In IDLE, MEM_WR or MEM_RD high at a rising edge SHALL accept a request and latch MAR, MDR and the operation type.
REQ-016 If MEM_WR and MEM_RD are both high at acceptance, the access SHALL be treated as a write and the read SHALL be ignored.
REQ-017 On acceptance, the FSM SHALL go IDLE->BUSY with the wait counter = WAIT_CYCLES-1; with WAIT_CYCLES=0 it SHALL go IDLE->RESP directly.
REQ-018 In BUSY, the counter SHALL decrement each cycle, and BUSY->RESP SHALL occur on the edge where the counter is 0.
REQ-019 MEM_READY SHALL be high exactly during the single RESP cycle, i.e. cycle WAIT_CYCLES+1 counting the acceptance cycle as 0; RESP->IDLE is unconditional.
REQ-020 MEM_BUSY SHALL be high in BUSY and RESP and low in IDLE.
REQ-021 Strobes and MAR/MDR changes SHALL be ignored outside IDLE; latched values alone determine the access.
REQ-022 A strobe still high in the IDLE cycle after RESP SHALL be accepted as a new request (back-to-back, one idle cycle minimum).
REQ-023 Latched address 0xFFFF SHALL be the I/O port; every other address SHALL map to RAM.
REQ-024 RAM addressing SHALL use the low DEPTH_LOG2 bits of the address (wrap-around aliasing), excluding 0xFFFF.
REQ-025 A write SHALL commit to RAM, or to HEX_Data for 0xFFFF, on the edge entering RESP and not earlier.
REQ-026 A read SHALL load Data_to_CPU on the edge entering RESP; the value is RAM[addr], or the synchronized SW for 0xFFFF.
REQ-027 Data_to_CPU SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-028 SW SHALL pass through a two-flop synchronizer; an I/O read SHALL return the synchronizer output at the RESP-entry edge.
REQ-029 RAM contents SHALL NOT be initialized or cleared by Reset.

Reset
REQ-030 Reset SHALL force state=IDLE, counter=0, MEM_READY=0, MEM_BUSY=0, Data_to_CPU=0x0000, HEX_Data=0x0000 and both synchronizer flops to 0.
REQ-031 Reset asserted in BUSY or RESP SHALL abort the access: no RAM/HEX write commits unless its commit edge already occurred, and no MEM_READY pulse follows.
REQ-032 After Reset deasserts, the first rising edge with a strobe high in IDLE SHALL be accepted normally.

Verification
REQ-033 WAIT_CYCLES=2: write MAR=0x0010, MDR=0xBEEF, then read 0x0010 -> MEM_READY in cycle 3 of each access, Data_to_CPU=0xBEEF.
REQ-034 Alias: write 0x0105 data 0x1234 (DEPTH_LOG2=8), then read 0x0005 -> 0x1234; write 0xFFFF data 0x00A5 -> HEX_Data=0x00A5 and RAM unchanged.
REQ-035 I/O read: SW=0x5A5A held at least 3 cycles, then read 0xFFFF -> Data_to_CPU=0x5A5A; a SW change during BUSY less than 2 cycles before RESP entry is not seen.
REQ-036 MEM_RD=MEM_WR=1 with MAR=0x0020, MDR=0x7777 -> write occurs; Data_to_CPU keeps its prior value; a later read of 0x0020 gives 0x7777.
REQ-037 Write 0x0030 data 0xCAFE with Reset pulsed during BUSY -> no MEM_READY, a later read of 0x0030 returns its pre-test value, Data_to_CPU=0x0000 after reset.
REQ-038 WAIT_CYCLES=0 with MEM_RD held high for 6 cycles -> MEM_READY in cycles 1, 3 and 5 (alternating IDLE/RESP).
